// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive capture block.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Baud count at which the middle of the start bit is reached.
    function automatic int mid_bit_count(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead FIFO with a registered head: o_data/o_valid reflect the entry that
// will be at the head after this cycle's push/pop.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_wr_ptr_nxt;
    logic [AW:0]      w_rd_ptr_nxt;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop     = i_pop && !w_empty;
    assign w_do_push    = i_push && (!w_full || w_do_pop);
    assign w_wr_ptr_nxt = w_do_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_rd_ptr_nxt = w_do_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // The new head may be the byte being written this very cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_valid  <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
            if (w_do_push && (w_rd_ptr_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
                r_data <= i_data;
            end else begin
                r_data <= r_mem[w_rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling FSM and a byte FIFO
// presented on a valid/ready interface.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_serial,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic [31:0] rx_count,
    output logic        busy
);

    localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] MID_CNT  = BAUD_W'(mid_bit_count(CLKS_PER_BIT));
    localparam logic [BAUD_W-1:0] LAST_CNT = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]    r_sync;
    uart_rx_state_t            r_state;
    logic [BAUD_W-1:0]         r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_push;
    logic                      r_frame_err;
    logic                      r_overflow;
    logic [31:0]               r_rx_count;

    logic w_rxs;
    logic w_full;
    logic w_empty;
    logic w_valid;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    // Reset high so a line held low across reset is not seen as a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    if (!w_rxs) r_state <= START;
                end
                START: begin
                    if (r_baud_cnt == MID_CNT) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (r_baud_cnt == LAST_CNT) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch the next start edge.
                    if (r_baud_cnt == LAST_CNT) begin
                        r_baud_cnt <= '0;
                        if (w_rxs) begin
                            r_push  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                BREAK: begin
                    r_baud_cnt <= '0;
                    if (w_rxs) r_state <= IDLE;
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // A full FIFO still takes the byte when the consumer pops in the same cycle.
    assign w_pop    = w_valid && rx_ready;
    assign w_accept = r_push && (!w_full || w_pop);
    assign w_drop   = r_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_rx_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_accept) begin
                r_rx_count <= r_rx_count + 32'd1;
            end
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (rx_data),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = w_valid;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign rx_count  = r_rx_count;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: serial frames driven on the falling clock
// edge, popped bytes collected by a monitor and compared against exp_q.
module tb_uart_rx_capture;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_serial;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overflow;
    logic        clr_overflow;
    logic [31:0] rx_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt;
    int         valid_cycles;

    uart_rx_capture #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .rx_count     (rx_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Sample mid-low-phase, after the driver's negedge updates have settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic ready);
        rst          = 1'b1;
        rx_serial    = 1'b1;
        rx_ready     = ready;
        clr_overflow = 1'b0;
        idle(3);
        got_q.delete();
        exp_q.delete();
        fe_cnt       = 0;
        valid_cycles = 0;
        rst          = 1'b0;
        idle(2);
    endtask

    // Drives the first nbits of {stop, data, start}, LSB first.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits);
        logic [9:0] f;
        f = {stop_b, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_serial = f[i];
            idle(CPB);
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead_beef,
                  32'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1; rx_serial = 1'b1; rx_ready = 1'b1; clr_overflow = 1'b0;
        fe_cnt = 0; valid_cycles = 0;

        // Reset values
        do_reset(1'b1);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", rx_count, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single byte
        send_frame(8'h48, 1'b1, 10);
        idle(12);
        exp_q.push_back(8'h48);
        check_stream("single");
        check("single_valid_cycles", 32'(valid_cycles), 32'd1);
        check("single_ferr", 32'(fe_cnt), 32'd0);
        check("single_count", rx_count, 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        // Back-to-back frames, no idle gap
        do_reset(1'b1);
        send_frame(8'h48, 1'b1, 10);
        send_frame(8'h69, 1'b1, 10);
        send_frame(8'h0A, 1'b1, 10);
        idle(12);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h0A);
        check_stream("b2b");
        check("b2b_count", rx_count, 32'd3);
        check("b2b_ferr", 32'(fe_cnt), 32'd0);

        // One-clock glitch
        do_reset(1'b1);
        rx_serial = 1'b0;
        idle(1);
        rx_serial = 1'b1;
        idle(10);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_bytes", 32'(got_q.size()), 32'd0);
        check("glitch_count", rx_count, 32'd0);

        // Framing error: stop bit low, line held low 20 clocks
        send_frame(8'h55, 1'b0, 9);
        rx_serial = 1'b0;
        idle(20);
        check("ferr_pulses", 32'(fe_cnt), 32'd1);
        check("ferr_busy_low", 32'(busy), 32'd1);
        check("ferr_bytes", 32'(got_q.size()), 32'd0);
        check("ferr_count", rx_count, 32'd0);
        rx_serial = 1'b1;
        idle(6);
        check("ferr_busy_high", 32'(busy), 32'd0);
        check("ferr_pulses_after", 32'(fe_cnt), 32'd1);

        // Overflow: 17 bytes into a 16-entry FIFO with the consumer stalled
        do_reset(1'b0);
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1, 10);
        end
        idle(12);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", rx_count, 32'd16);
        check("ovf_valid", 32'(rx_valid), 32'd1);
        check("ovf_head", 32'(rx_data), 32'h00);
        check("ovf_no_pops", 32'(got_q.size()), 32'd0);
        rx_ready = 1'b1;
        idle(24);
        for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
        check_stream("ovf_drain");
        check("ovf_drained_valid", 32'(rx_valid), 32'd0);
        check("ovf_flag_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        idle(1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Reset during data bit 4 of 0xA5, then a clean 0x3C
        do_reset(1'b1);
        send_frame(8'hA5, 1'b1, 5);
        rx_serial = 1'b0;
        idle(2);
        rst = 1'b1;
        rx_serial = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(10);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        check("mid_rst_count", rx_count, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ferr", 32'(fe_cnt), 32'd0);
        check("mid_rst_bytes", 32'(got_q.size()), 32'd0);
        send_frame(8'h3C, 1'b1, 10);
        idle(12);
        exp_q.push_back(8'h3C);
        check_stream("post_rst");
        check("post_rst_count", rx_count, 32'd1);
        check("post_rst_ferr", 32'(fe_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
